// File: rtl/bus_arbiter_if.sv
// Shared external bus arbitration signals.
// master: requester side; slave: arbiter side.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_id;
    logic            bus_busy;
    logic            timeout;
    logic [2:0]      timeout_id;

    modport master (
        output req,
        input  gnt, gnt_id, bus_busy, timeout, timeout_id
    );

    modport slave (
        input  req,
        output gnt, gnt_id, bus_busy, timeout, timeout_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with turnaround cycle and hold timeout.
// Optional CPU_PRIO_EN: requester 0 wins and preempts other owners.
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 5
) (
    input logic         clk,
    input logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } state_t;

    localparam logic [2:0]      LAST      = 3'(NREQ - 1);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

    state_t          state, state_n;
    logic [NREQ-1:0] gnt, gnt_n, win_oh;
    logic [2:0]      gnt_id, id_n;
    logic [2:0]      rr_ptr, rr_n;
    logic [2:0]      toid, toid_n;
    logic [2:0]      win, rr_next;
    logic [CNTW-1:0] hold_cnt, cnt_n;
    logic            to, to_n;
    logic            found, own_req, hold_done, preempt;

    // Rotated scan: first from rr_ptr upward, then wrap to the low indices.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
`ifdef CPU_PRIO_EN
        if (bus.req[0]) begin
            found = 1'b1;
            win   = 3'd0;
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i] && i >= int'(rr_ptr)) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i]) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = (win == 3'(i));
        end
    end

    assign own_req   = |(bus.req & gnt);
    assign hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign rr_next   = (gnt_id == LAST) ? 3'd0 : gnt_id + 3'd1;

`ifdef CPU_PRIO_EN
    assign preempt = bus.req[0] && (gnt_id != 3'd0);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        id_n    = gnt_id;
        rr_n    = rr_ptr;
        cnt_n   = hold_cnt;
        to_n    = 1'b0;
        toid_n  = toid;
        case (state)
            IDLE, TURN: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = win_oh;
                    id_n    = win;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    id_n    = 3'd0;
                end
            end
            GRANT: begin
                if (!own_req || preempt || hold_done) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    id_n    = 3'd0;
                    cnt_n   = '0;
`ifdef CPU_PRIO_EN
                    if (gnt_id != 3'd0) rr_n = rr_next;
`else
                    rr_n = rr_next;
`endif
                    // A revoke only counts as a timeout if the owner still wanted the bus.
                    to_n = own_req && hold_done && !preempt;
                    if (to_n) toid_n = gnt_id;
                end else if (hold_cnt != '1) begin
                    cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                id_n    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= 3'd0;
            rr_ptr   <= 3'd0;
            hold_cnt <= '0;
            to       <= 1'b0;
            toid     <= 3'd0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            rr_ptr   <= rr_n;
            hold_cnt <= cnt_n;
            to       <= to_n;
            toid     <= toid_n;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.gnt_id     = gnt_id;
    assign bus.bus_busy   = |gnt;
    assign bus.timeout    = to;
    assign bus.timeout_id = toid;
endmodule
